// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter.
// Widths and unit ids mirror the core-wide defines so the CDB matches the ROB and register lock table.
package cdb_arbiter_pkg;

  localparam int REG_LOCK_W = 5;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;

  // Tag meaning "no register lock"; the arbiter passes it through untouched.
  localparam logic [REG_LOCK_W-1:0] REG_NO_LOCK = 5'h1F;

  localparam int CDB_REQ_NUM = 4;
  localparam int CDB_PTR_W   = 2;

  localparam int CDB_ALU = 0;
  localparam int CDB_LSM = 1;
  localparam int CDB_BR  = 2;
  localparam int CDB_MD  = 3;

  typedef struct packed {
    logic                  valid;
    logic [REG_LOCK_W-1:0] index;
    logic [DATA_W-1:0]     data;
    logic [ADDR_W-1:0]     addr;
  } cdb_bcast_t;

  localparam cdb_bcast_t CDB_BCAST_RST = '{
    valid: 1'b0,
    index: REG_NO_LOCK,
    data:  '0,
    addr:  '0
  };

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of requester payloads, grant and registered CDB broadcast.
import cdb_arbiter_pkg::*;

// Handshake: unit i raises req_valid[i] with its payload and holds both
// stable until it sees grnt[i] high in the same cycle; that cycle is the
// transfer, and the unit may drop or replace its request afterwards.
// grnt is the ready side and is never high without the matching req_valid.
interface cdb_arbiter_if #(
  parameter int N_REQ = CDB_REQ_NUM,
  parameter int PTR_W = CDB_PTR_W
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*REG_LOCK_W-1:0] req_index;
  logic [N_REQ*DATA_W-1:0]     req_data;
  logic [N_REQ*ADDR_W-1:0]     req_addr;
  logic                        rob_stall;
  logic [N_REQ-1:0]            grnt;
  logic                        cdb_valid;
  logic [REG_LOCK_W-1:0]       cdb_index;
  logic [DATA_W-1:0]           cdb_data;
  logic [ADDR_W-1:0]           cdb_addr;
  logic [PTR_W-1:0]            cdb_src;
  logic [15:0]                 conflict_cnt;

  modport master (
    output req_valid, req_index, req_data, req_addr, rob_stall,
    input  grnt, cdb_valid, cdb_index, cdb_data, cdb_addr, cdb_src, conflict_cnt
  );

  modport slave (
    input  req_valid, req_index, req_data, req_addr, rob_stall,
    output grnt, cdb_valid, cdb_index, cdb_data, cdb_addr, cdb_src, conflict_cnt
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-winner CDB arbiter: same-cycle round-robin grant, broadcast registered one cycle later.
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
  parameter int N_REQ = CDB_REQ_NUM,
  parameter int PTR_W = CDB_PTR_W
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  logic [PTR_W-1:0]      ptr;
  logic [N_REQ-1:0]      pick_req;
  logic [N_REQ-1:0]      grant;
  logic [PTR_W-1:0]      winner;
  logic                  granted;
  logic                  multi_req;
  logic [15:0]           conflict_cnt;
  logic [PTR_W-1:0]      cdb_src;
  cdb_bcast_t            bcast;
  logic [REG_LOCK_W-1:0] sel_index;
  logic [DATA_W-1:0]     sel_data;
  logic [ADDR_W-1:0]     sel_addr;

  // Reset and ROB back-pressure both suppress grants at the picker input,
  // so the pointer and broadcast logic only ever see a legal winner.
  assign pick_req = (rst || bus.rob_stall) ? '0 : bus.req_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (pick_req),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (granted)
  );

  assign multi_req = (bus.req_valid & (bus.req_valid - N_REQ'(1))) != '0;

  always_comb begin
    sel_index = '0;
    sel_data  = '0;
    sel_addr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_index = bus.req_index[i*REG_LOCK_W +: REG_LOCK_W];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      bcast        <= CDB_BCAST_RST;
      cdb_src      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (granted) begin
        ptr         <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
        bcast.valid <= 1'b1;
        bcast.index <= sel_index;
        bcast.data  <= sel_data;
        bcast.addr  <= sel_addr;
        cdb_src     <= winner;
      end else begin
        // Data, address and source hold so the bus only toggles on real results.
        bcast.valid <= 1'b0;
        bcast.index <= REG_NO_LOCK;
      end
      if (multi_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  assign bus.grnt         = grant;
  assign bus.cdb_valid    = bcast.valid;
  assign bus.cdb_index    = bcast.index;
  assign bus.cdb_data     = bcast.data;
  assign bus.cdb_addr     = bcast.addr;
  assign bus.cdb_src      = cdb_src;
  assign bus.conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant order, broadcast latency, stall, wrap and reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int u, input logic [4:0] idx, input logic [31:0] d,
                      input logic [31:0] a);
    bus.req_index[u*REG_LOCK_W +: REG_LOCK_W] = idx;
    bus.req_data[u*DATA_W +: DATA_W]          = d;
    bus.req_addr[u*ADDR_W +: ADDR_W]          = a;
  endtask

  task automatic check_bcast(input string tag, input logic v, input logic [4:0] idx,
                             input logic [31:0] d, input logic [1:0] src);
    check({tag, "_valid"}, 32'(bus.cdb_valid), 32'(v));
    check({tag, "_index"}, 32'(bus.cdb_index), 32'(idx));
    check({tag, "_data"},  bus.cdb_data, d);
    check({tag, "_src"},   32'(bus.cdb_src), 32'(src));
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rob_stall = 1'b0;
    bus.req_index = '0;
    bus.req_data  = '0;
    bus.req_addr  = '0;

    step();
    check("grnt_in_rst", 32'(bus.grnt), 32'h0);
    step();
    rst           = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    check_bcast("rst", 1'b0, 5'h1F, 32'h0, 2'd0);
    check("rst_addr", bus.cdb_addr, 32'h0);
    check("rst_cc", 32'(bus.conflict_cnt), 32'd0);
    check("rst_ptr", 32'(dut.ptr), 32'd0);

    // Single request from LSM.
    load(1, 5'h03, 32'hDEADBEEF, 32'h0000_1000);
    bus.req_valid = 4'b0010;
    #1 check("single_grnt", 32'(bus.grnt), 32'b0010);
    step();
    check_bcast("single", 1'b1, 5'h03, 32'hDEADBEEF, 2'd1);
    check("single_addr", bus.cdb_addr, 32'h0000_1000);
    check("single_ptr", 32'(dut.ptr), 32'd2);

    // Back-to-back grant to BRANCH moves ptr to 3.
    load(2, 5'h07, 32'h2222_2222, 32'h0000_2000);
    bus.req_valid = 4'b0100;
    #1 check("b2b_grnt", 32'(bus.grnt), 32'b0100);
    step();
    check_bcast("b2b", 1'b1, 5'h07, 32'h2222_2222, 2'd2);
    check("b2b_ptr", 32'(dut.ptr), 32'd3);

    // Wrap: ptr 3 with units 0 and 3 requesting.
    load(0, 5'h0A, 32'hAAAA_0000, 32'h0);
    load(3, 5'h0C, 32'h3333_3333, 32'h0000_3000);
    bus.req_valid = 4'b1001;
    #1 check("wrap_grnt", 32'(bus.grnt), 32'b1000);
    step();
    check_bcast("wrap", 1'b1, 5'h0C, 32'h3333_3333, 2'd3);
    check("wrap_ptr", 32'(dut.ptr), 32'd0);
    check("wrap_cc", 32'(bus.conflict_cnt), 32'd1);
    bus.req_valid = 4'b0001;
    #1 check("wrap_next_grnt", 32'(bus.grnt), 32'b0001);
    step();
    check_bcast("wrap_next", 1'b1, 5'h0A, 32'hAAAA_0000, 2'd0);
    check("wrap_next_ptr", 32'(dut.ptr), 32'd1);

    // Idle cycle: valid drops, payload holds.
    bus.req_valid = 4'b0000;
    #1 check("idle_grnt", 32'(bus.grnt), 32'h0);
    step();
    check_bcast("idle", 1'b0, 5'h1F, 32'hAAAA_0000, 2'd0);
    check("idle_ptr", 32'(dut.ptr), 32'd1);

    // Grant MULDIV alone to bring ptr back to 0.
    bus.req_valid = 4'b1000;
    #1 check("align_grnt", 32'(bus.grnt), 32'b1000);
    step();
    check("align_ptr", 32'(dut.ptr), 32'd0);

    // All four requesting for 8 cycles.
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("rr_grnt%0d", k), 32'(bus.grnt), 32'(1 << (k % 4)));
      step();
      check($sformatf("rr_src%0d", k), 32'(bus.cdb_src), 32'(k % 4));
    end
    bus.req_valid = 4'b0000;
    check("rr_cc", 32'(bus.conflict_cnt), 32'd9);
    check("rr_ptr", 32'(dut.ptr), 32'd0);
    step();
    check("pre_stall_valid", 32'(bus.cdb_valid), 32'd0);

    // ROB stall for three cycles with BRANCH requesting.
    bus.req_valid = 4'b0100;
    bus.rob_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("stall_grnt%0d", k), 32'(bus.grnt), 32'h0);
      step();
      check($sformatf("stall_valid%0d", k), 32'(bus.cdb_valid), 32'd0);
      check($sformatf("stall_ptr%0d", k), 32'(dut.ptr), 32'd0);
    end
    bus.rob_stall = 1'b0;
    #1 check("unstall_grnt", 32'(bus.grnt), 32'b0100);
    check("unstall_valid_pre", 32'(bus.cdb_valid), 32'd0);
    step();
    check_bcast("unstall", 1'b1, 5'h07, 32'h2222_2222, 2'd2);
    check("unstall_ptr", 32'(dut.ptr), 32'd3);

    // Stall right after a grant: broadcast still shows, no new grant, conflicts counted.
    bus.rob_stall = 1'b1;
    bus.req_valid = 4'b1001;
    #1 check("sag_grnt", 32'(bus.grnt), 32'h0);
    check("sag_valid", 32'(bus.cdb_valid), 32'd1);
    step();
    check_bcast("sag_after", 1'b0, 5'h1F, 32'h2222_2222, 2'd2);
    check("sag_ptr", 32'(dut.ptr), 32'd3);
    check("sag_cc", 32'(bus.conflict_cnt), 32'd10);
    bus.rob_stall = 1'b0;
    #1 check("sag_resume_grnt", 32'(bus.grnt), 32'b1000);
    step();
    check_bcast("sag_resume", 1'b1, 5'h0C, 32'h3333_3333, 2'd3);
    check("sag_resume_ptr", 32'(dut.ptr), 32'd0);
    check("sag_resume_cc", 32'(bus.conflict_cnt), 32'd11);

    // Reset in the cycle after a grant.
    rst           = 1'b1;
    bus.req_valid = 4'b0001;
    #1 check("mrst_grnt", 32'(bus.grnt), 32'h0);
    check("mrst_valid_pre", 32'(bus.cdb_valid), 32'd1);
    step();
    rst = 1'b0;
    check_bcast("mrst", 1'b0, 5'h1F, 32'h0, 2'd0);
    check("mrst_addr", bus.cdb_addr, 32'h0);
    check("mrst_ptr", 32'(dut.ptr), 32'd0);
    check("mrst_cc", 32'(bus.conflict_cnt), 32'd0);

    // The no-lock tag is arbitrated and broadcast like any other.
    load(0, 5'h1F, 32'h5A5A_5A5A, 32'h0000_4000);
    #1 check("nolock_grnt", 32'(bus.grnt), 32'b0001);
    step();
    bus.req_valid = 4'b0000;
    check_bcast("nolock", 1'b1, 5'h1F, 32'h5A5A_5A5A, 2'd0);
    check("nolock_addr", bus.cdb_addr, 32'h0000_4000);
    check("nolock_ptr", 32'(dut.ptr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
